sys_bus_arbiter: RTL and testbench
==================================

Name: sys_bus_arbiter

Overview:
- Round-robin arbiter that shares one Red Pitaya system bus slave port between MN masters (e.g. PS-AXI bridge plus a DMA/sequencer).
- Each master uses the standard sys bus handshake: a one-cycle wen/ren pulse, address/data held stable until ack/err.
- The arbiter latches requests, issues them one at a time to the slave and routes the ack/err/rdata back.
- A per-transfer timeout returns err if the slave never answers.

Parameters:
- MN, 2, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- SW, DW/8, byte-select width.
- TIMEOUT, 255, slave-response timeout in cycles (1..65535); 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- m_addr  in  MN*AW  master addresses; master i uses slice [i*AW +: AW].
- m_wdata  in  MN*DW  master write data.
- m_sel  in  MN*SW  master byte selects.
- m_wen  in  MN  master write-enable pulses.
- m_ren  in  MN  master read-enable pulses.
- m_rdata  out  DW  read data, shared by all masters; valid with that master's m_ack.
- m_ack  out  MN  per-master acknowledge pulse.
- m_err  out  MN  per-master error pulse.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_sel  out  SW  slave byte select.
- s_wen  out  1  slave write pulse.
- s_ren  out  1  slave read pulse.
- s_rdata  in  DW  slave read data.
- s_err  in  1  slave error.
- s_ack  in  1  slave acknowledge.

Behaviour:
- Reset values:
  - all outputs 0.
  - pend[MN] = 0, dir[MN] = 0, state = IDLE, timeout counter = 0.
  - last-grant pointer = MN-1, so master 0 wins the first arbitration.
- Request capture:
  - Sampled m_wen[i] | m_ren[i] sets pend[i] and dir[i] (1 = write).
  - If m_wen[i] and m_ren[i] are both high, the request is a write.
  - A pulse while pend[i] is already 1 is ignored: no second transfer, dir unchanged.
  - If set and clear of pend[i] fall on the same edge, set wins.
- Master obligation: m_addr, m_wdata and m_sel slices stay stable from the pulse until m_ack or m_err. The arbiter does not latch them before grant.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any pend is set, grant = first set index searching last+1, last+2, ... modulo MN.
  - On that edge, register s_addr, s_wdata and s_sel from the granted slice, and s_wen = dir, s_ren = ~dir.
  - Go to ISSUE.
- ISSUE:
  - s_wen/s_ren are high for exactly this one cycle, then drop to 0.
  - Clear the timeout counter and go to WAIT.
  - s_addr, s_wdata and s_sel hold until the next grant.
- WAIT:
  - If s_ack | s_err is sampled high, on that edge: m_ack[grant] <= s_ack, m_err[grant] <= s_err & ~s_ack, m_rdata <= s_rdata.
  - On the same edge: clear pend[grant], last <= grant, go to IDLE.
  - If no response, the counter increments each cycle. When it reaches TIMEOUT-1 with no response, m_err[grant] is pulsed, pend is cleared, last is updated and the FSM goes to IDLE.
  - With TIMEOUT = 0 the FSM waits forever.
- Response pulses: m_ack and m_err are high for exactly one cycle. m_rdata holds its value until the next response.
- Stray responses: s_ack or s_err seen in IDLE or ISSUE, including a late ack after a timeout, is ignored and not forwarded.
- Latency:
  - Pulse in cycle t → pend visible t+1 → s_wen/s_ren high in t+2.
  - Slave ack in cycle a → m_ack in a+1.
  - Minimum master-to-master turnaround is 4 cycles.
- Fairness: with all masters continuously requesting, grants rotate 0,1,...,MN-1,0,... and each master is served within MN transfers.
- Reset mid-transfer: immediate return to reset values. Pending requests are dropped and no ack is generated.

Test Plan:
- Single write, MN=2: master 0 writes addr 0x40000010, data 0xDEADBEEF; slave acks 1 cycle after s_wen → s_wen high exactly in cycle t+2 with s_addr=0x40000010, s_wdata=0xDEADBEEF, s_sel=0xF; m_ack[0] one-cycle pulse; m_ack[1]=0.
- Read routing: master 1 reads 0x40100000; slave returns s_rdata=0x12345678 with 3-cycle delay → m_ack[1] pulse with m_rdata=0x12345678; no pulse on m_ack[0]/m_err.
- Contention: both masters pulse in the same cycle, 4 back-to-back rounds → grant order 0,1,0,1; each issued transfer drives the requester's address.
- Timeout, TIMEOUT=16: slave never acks → m_err[grant] pulse after 16 cycles in WAIT (counter reaching 15); a late s_ack 5 cycles later produces no m_ack.
- Slave error: slave asserts s_err on a write to 0x40F00000 → m_err pulse, m_ack stays 0, pend cleared; a next request is served normally.
- Reset mid-WAIT: deassert rstn during WAIT with master 1 pending → all outputs 0, no m_ack; after release, master 0 is granted first.

Source files
------------

// File: rtl/sys_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sys_bus_arbiter
//   Round-robin arbiter sharing one Red Pitaya system-bus slave between MN
//   masters. Each master fires a one-cycle wen/ren pulse and holds its
//   address/data/select stable until it gets ack or err. Requests are latched
//   as pending bits, issued one at a time and the slave answer is routed back
//   to the granted master. A per-transfer timeout turns a silent slave into err.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   m_addr/m_wdata/m_sel      packed master request slices (master i at i*W)
//   m_wen/m_ren               per-master request pulses (both high = write)
//   m_rdata                   shared read data, valid with the m_ack pulse
//   m_ack/m_err               per-master one-cycle response pulses
//   s_addr/s_wdata/s_sel      slave request, held from grant to next grant
//   s_wen/s_ren               slave one-cycle request pulse
//   s_rdata/s_ack/s_err       slave response
// ---------------------------------------------------------------------------
module sys_bus_arbiter #(
    parameter int MN      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW/8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [MN*AW-1:0] m_addr,
    input  logic [MN*DW-1:0] m_wdata,
    input  logic [MN*SW-1:0] m_sel,
    input  logic [MN-1:0]    m_wen,
    input  logic [MN-1:0]    m_ren,
    output logic [DW-1:0]    m_rdata,
    output logic [MN-1:0]    m_ack,
    output logic [MN-1:0]    m_err,
    output logic [AW-1:0]    s_addr,
    output logic [DW-1:0]    s_wdata,
    output logic [SW-1:0]    s_sel,
    output logic             s_wen,
    output logic             s_ren,
    input  logic [DW-1:0]    s_rdata,
    input  logic             s_err,
    input  logic             s_ack
);

    localparam int GW = (MN > 1) ? $clog2(MN) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [MN-1:0]   pend_q, pend_d;
    logic [MN-1:0]   dir_q, dir_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [DW-1:0]   m_rdata_q, m_rdata_d;
    logic [MN-1:0]   m_ack_q, m_ack_d;
    logic [MN-1:0]   m_err_q, m_err_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [SW-1:0]   s_sel_q, s_sel_d;
    logic            s_wen_q, s_wen_d;
    logic            s_ren_q, s_ren_d;

    logic [MN-1:0]   pend_clr;
    logic [MN-1:0]   take;
    logic [GW-1:0]   arb_idx;
    logic            arb_hit;

    // Round-robin search starting just after the last served master.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = last_q;
        for (int k = 1; k <= MN; k++) begin
            if (!arb_hit && pend_q[(int'(last_q) + k) % MN]) begin
                arb_hit = 1'b1;
                arb_idx = GW'((int'(last_q) + k) % MN);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_rdata_d = m_rdata_q;
        m_ack_d   = '0;
        m_err_d   = '0;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_sel_d   = s_sel_q;
        s_wen_d   = s_wen_q;
        s_ren_d   = s_ren_q;
        pend_clr  = '0;

        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    grant_d   = arb_idx;
                    s_addr_d  = m_addr[int'(arb_idx)*AW +: AW];
                    s_wdata_d = m_wdata[int'(arb_idx)*DW +: DW];
                    s_sel_d   = m_sel[int'(arb_idx)*SW +: SW];
                    s_wen_d   = dir_q[arb_idx];
                    s_ren_d   = ~dir_q[arb_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                s_wen_d = 1'b0;
                s_ren_d = 1'b0;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (s_ack || s_err) begin
                    m_ack_d[grant_q]  = s_ack;
                    m_err_d[grant_q]  = s_err & ~s_ack;
                    m_rdata_d         = s_rdata;
                    pend_clr[grant_q] = 1'b1;
                    last_d            = grant_q;
                    state_d           = IDLE;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    m_err_d[grant_q]  = 1'b1;
                    pend_clr[grant_q] = 1'b1;
                    last_d            = grant_q;
                    state_d           = IDLE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pulse on an already-pending master is dropped, except on the edge
        // that retires that master's transfer: there the new request is kept.
        take   = (m_wen | m_ren) & (~pend_q | pend_clr);
        pend_d = (pend_q & ~pend_clr) | take;
        dir_d  = (dir_q & ~take) | (m_wen & take);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            dir_q     <= '0;
            grant_q   <= '0;
            last_q    <= GW'(MN - 1);
            cnt_q     <= '0;
            m_rdata_q <= '0;
            m_ack_q   <= '0;
            m_err_q   <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_sel_q   <= '0;
            s_wen_q   <= 1'b0;
            s_ren_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            dir_q     <= dir_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_rdata_q <= m_rdata_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_sel_q   <= s_sel_d;
            s_wen_q   <= s_wen_d;
            s_ren_q   <= s_ren_d;
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_sel   = s_sel_q;
    assign s_wen   = s_wen_q;
    assign s_ren   = s_ren_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sys_bus_arbiter
//   Directed scenarios plus a randomized two-master run. A background slave
//   process answers issued transfers; a transaction-level model predicts the
//   round-robin grant and the response each master should see.
// ---------------------------------------------------------------------------
module tb_sys_bus_arbiter;

    localparam int MN = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic [MN*AW-1:0] m_addr;
    logic [MN*DW-1:0] m_wdata;
    logic [MN*SW-1:0] m_sel;
    logic [MN-1:0]    m_wen, m_ren;
    logic [DW-1:0]    m_rdata;
    logic [MN-1:0]    m_ack, m_err;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [SW-1:0]    s_sel;
    logic             s_wen, s_ren;
    logic [DW-1:0]    s_rdata;
    logic             s_err, s_ack;

    sys_bus_arbiter #(.MN(MN), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
        .m_wen(m_wen), .m_ren(m_ren),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel),
        .s_wen(s_wen), .s_ren(s_ren),
        .s_rdata(s_rdata), .s_err(s_err), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // slave behaviour: kind 0 = ack, 1 = err, 2 = never answer
    int          slv_kind = 0;
    int          slv_dly  = 1;
    int          slv_late = 0;
    logic [31:0] slv_rd   = '0;
    bit          slv_rand = 1'b0;

    typedef struct { int c; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; logic w; logic r; } iss_t;
    typedef struct { int k; logic [DW-1:0] rd; } rsp_t;
    iss_t iss_q[$];
    rsp_t rsp_q[$];

    int mdl_last;

    function automatic int rr_pick(input logic [MN-1:0] mask, input int last);
        for (int k = 1; k <= MN; k++) begin
            if (mask[(last + k) % MN]) return (last + k) % MN;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic w, input logic r,
                             input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_sel[i*SW +: SW]   = s;
        m_wen[i]            = w;
        m_ren[i]            = r;
    endtask

    task automatic wait_resp(input int max, output logic [MN-1:0] ack, output logic [MN-1:0] err, output int at);
        ack = '0; err = '0; at = -1;
        for (int n = 0; n < max; n++) begin
            tick();
            if (m_ack != '0 || m_err != '0) begin
                ack = m_ack; err = m_err; at = cyc;
                return;
            end
        end
        total++; bad++;
        $display("FAIL resp_wait: no m_ack/m_err within %0d cycles", max);
    endtask

    // Background slave: logs every issued transfer and answers it.
    initial begin
        iss_t it;
        rsp_t rp;
        int   k, d, n, r;
        s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (s_wen || s_ren) begin
                it.c = cyc; it.a = s_addr; it.d = s_wdata; it.s = s_sel; it.w = s_wen; it.r = s_ren;
                iss_q.push_back(it);
                if (slv_rand) begin
                    r = int'($urandom_range(0, 9));
                    k = (r == 0) ? 2 : (r < 3) ? 1 : 0;
                    d = int'($urandom_range(1, 4));
                    rp.rd = $urandom;
                end else begin
                    k = slv_kind; d = slv_dly; rp.rd = slv_rd;
                end
                rp.k = k;
                rsp_q.push_back(rp);
                n = (k != 2) ? d : (slv_late > 0 && !slv_rand) ? 17 + slv_late : 1;
                for (int j = 0; j < n; j++) begin
                    @(posedge clk); #1;
                    if (j == 0) begin
                        total++;
                        if (s_wen || s_ren) begin
                            bad++;
                            $display("FAIL issue_pulse_width: s_wen=%b s_ren=%b one cycle after issue, want 0", s_wen, s_ren);
                        end
                    end
                end
                if (k != 2 || (slv_late > 0 && !slv_rand)) begin
                    s_ack = (k != 1); s_err = (k == 1); s_rdata = rp.rd;
                    @(posedge clk); #1;
                    s_ack = 1'b0; s_err = 1'b0;
                end
            end
        end
    end

    task automatic test_reset();
        rstn = 1'b0;
        m_addr = '0; m_wdata = '0; m_sel = '0; m_wen = '0; m_ren = '0;
        repeat (3) tick();
        total++;
        if ({m_ack, m_err} !== '0) begin bad++; $display("FAIL reset_resp: ack=%b err=%b want 0", m_ack, m_err); end
        total++;
        if (m_rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
        total++;
        if ({s_addr, s_wdata, s_sel} !== '0) begin bad++; $display("FAIL reset_slave_bus: addr=%h wdata=%h sel=%h want 0", s_addr, s_wdata, s_sel); end
        total++;
        if ({s_wen, s_ren} !== 2'b00) begin bad++; $display("FAIL reset_slave_strobe: wen=%b ren=%b want 0", s_wen, s_ren); end
        rstn = 1'b1;
        mdl_last = MN - 1;
        repeat (3) tick();
        total++;
        if (iss_q.size() != 0) begin bad++; $display("FAIL idle_no_issue: %0d issues with no request, want 0", iss_q.size()); end
    endtask

    task automatic test_single_write();
        logic [MN-1:0] ack, err;
        int t0, at;
        iss_q.delete(); rsp_q.delete();
        slv_kind = 0; slv_dly = 1;
        drive_req(0, 1'b1, 1'b0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
        t0 = cyc;
        tick(); m_wen = '0; m_ren = '0;
        total++;
        if ({s_wen, s_ren} !== 2'b00) begin bad++; $display("FAIL wr_early_issue: wen=%b ren=%b at t+1, want 00", s_wen, s_ren); end
        tick();
        total++;
        if ({s_wen, s_ren} !== 2'b10) begin bad++; $display("FAIL wr_issue_strobe: wen/ren=%b%b at t+2, want 10", s_wen, s_ren); end
        total++;
        if ({s_addr, s_wdata, s_sel} !== {32'h4000_0010, 32'hDEAD_BEEF, 4'hF}) begin
            bad++; $display("FAIL wr_issue_bus: addr=%h wdata=%h sel=%h want 40000010 deadbeef f", s_addr, s_wdata, s_sel);
        end
        wait_resp(10, ack, err, at);
        total++;
        if (ack !== 2'b01 || err !== 2'b00 || at != t0 + 4) begin
            bad++; $display("FAIL wr_resp: ack=%b err=%b cycle=%0d want ack=01 err=00 cycle=%0d", ack, err, at, t0 + 4);
        end
        tick();
        total++;
        if (m_ack !== 2'b00) begin bad++; $display("FAIL wr_ack_width: m_ack=%b one cycle later, want 00", m_ack); end
        mdl_last = 0;
    endtask

    task automatic test_read_routing();
        logic [MN-1:0] ack, err;
        int t0, at;
        iss_q.delete(); rsp_q.delete();
        slv_kind = 0; slv_dly = 3; slv_rd = 32'h1234_5678;
        drive_req(1, 1'b0, 1'b1, 32'h4010_0000, 32'h0, 4'hF);
        t0 = cyc;
        tick(); m_wen = '0; m_ren = '0;
        tick();
        total++;
        if ({s_wen, s_ren, s_addr} !== {2'b01, 32'h4010_0000}) begin
            bad++; $display("FAIL rd_issue: wen/ren=%b%b addr=%h want 01 40100000", s_wen, s_ren, s_addr);
        end
        wait_resp(12, ack, err, at);
        total++;
        if (ack !== 2'b10 || err !== 2'b00 || at != t0 + 6) begin
            bad++; $display("FAIL rd_resp: ack=%b err=%b cycle=%0d want ack=10 err=00 cycle=%0d", ack, err, at, t0 + 6);
        end
        total++;
        if (m_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_data: m_rdata=%h want 12345678", m_rdata); end
        mdl_last = 1;
    endtask

    task automatic test_contention();
        logic [MN-1:0] ack, err, left;
        logic [AW-1:0] a [MN];
        int g [2];
        int at;
        slv_kind = 0; slv_dly = 1;
        for (int r = 0; r < 4; r++) begin
            iss_q.delete(); rsp_q.delete();
            a[0] = 32'h4000_0000 | 32'(r << 4);
            a[1] = 32'h4010_0000 | 32'(r << 4);
            drive_req(0, 1'b1, 1'b0, a[0], 32'(r), 4'h3);
            drive_req(1, 1'b0, 1'b1, a[1], 32'h0, 4'hC);
            tick(); m_wen = '0; m_ren = '0;
            left = '1;
            for (int j = 0; j < 2; j++) begin
                g[j] = rr_pick(left, mdl_last);
                wait_resp(20, ack, err, at);
                total++;
                if (ack !== MN'(1 << g[j]) || err !== '0) begin
                    bad++; $display("FAIL contention_grant: round %0d slot %0d ack=%b err=%b want master %0d", r, j, ack, err, g[j]);
                end
                left[g[j]] = 1'b0;
                mdl_last = g[j];
            end
            total++;
            if (iss_q.size() != 2 || iss_q[0].a !== a[g[0]] || iss_q[1].a !== a[g[1]]) begin
                bad++; $display("FAIL contention_addr: round %0d issues=%0d first=%h want %0d issues first=%h", r, iss_q.size(),
                                (iss_q.size() > 0) ? iss_q[0].a : 32'h0, 2, a[g[0]]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [MN-1:0] ack, err;
        int t0, at, stray;
        iss_q.delete(); rsp_q.delete();
        slv_kind = 2; slv_late = 5;
        drive_req(0, 1'b1, 1'b0, 32'h4020_0000, 32'h5555_AAAA, 4'hF);
        t0 = cyc;
        tick(); m_wen = '0; m_ren = '0;
        wait_resp(40, ack, err, at);
        total++;
        if (ack !== 2'b00 || err !== 2'b01 || at != t0 + 19) begin
            bad++; $display("FAIL timeout_err: ack=%b err=%b cycle=%0d want ack=00 err=01 cycle=%0d", ack, err, at, t0 + 19);
        end
        stray = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (m_ack != '0 || m_err != '0) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL late_ack_forwarded: %0d response cycles after timeout, want 0", stray); end
        total++;
        if (iss_q.size() != 1) begin bad++; $display("FAIL timeout_reissue: %0d issues, want 1", iss_q.size()); end
        slv_late = 0;
        mdl_last = 0;
    endtask

    task automatic test_slave_err();
        logic [MN-1:0] ack, err;
        int t0, at;
        iss_q.delete(); rsp_q.delete();
        slv_kind = 1; slv_dly = 2;
        drive_req(0, 1'b1, 1'b0, 32'h40F0_0000, 32'h0BAD_0BAD, 4'hF);
        t0 = cyc;
        tick(); m_wen = '0; m_ren = '0;
        wait_resp(12, ack, err, at);
        total++;
        if (ack !== 2'b00 || err !== 2'b01 || at != t0 + 5) begin
            bad++; $display("FAIL slv_err_resp: ack=%b err=%b cycle=%0d want ack=00 err=01 cycle=%0d", ack, err, at, t0 + 5);
        end
        repeat (5) tick();
        total++;
        if (iss_q.size() != 1) begin bad++; $display("FAIL slv_err_pend: %0d issues, want 1", iss_q.size()); end
        slv_kind = 0; slv_dly = 1; slv_rd = 32'hCAFE_F00D;
        drive_req(1, 1'b0, 1'b1, 32'h40F0_0004, 32'h0, 4'hF);
        tick(); m_wen = '0; m_ren = '0;
        wait_resp(12, ack, err, at);
        total++;
        if (ack !== 2'b10 || err !== 2'b00 || m_rdata !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL after_err_read: ack=%b err=%b rdata=%h want 10 00 cafef00d", ack, err, m_rdata);
        end
        mdl_last = 1;
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [AW-1:0] ra [MN];
        logic [DW-1:0] rd [MN];
        logic [SW-1:0] rs [MN];
        logic          rw [MN];
        bit            opend [MN];
        bit            gnt [MN];
        int            rcyc [MN];
        int            gap [MN];
        int            issued, done, op;
        logic [MN-1:0] elig;
        int            g;
        rsp_t          e;
        logic          xa, xe;
        iss_q.delete(); rsp_q.delete();
        slv_rand = 1'b1;
        issued = 0; done = 0;
        for (int i = 0; i < MN; i++) begin opend[i] = 0; gnt[i] = 0; gap[i] = 0; rcyc[i] = 0; end
        for (int n = 0; n < 4000 && done < N; n++) begin
            tick();
            for (int i = 0; i < MN; i++) begin
                if (m_ack[i] || m_err[i]) begin
                    total++;
                    if (!opend[i] || !gnt[i] || rsp_q.size() == 0) begin
                        bad++; $display("FAIL rnd_resp_unexpected: master %0d ack=%b err=%b", i, m_ack[i], m_err[i]);
                    end else begin
                        e  = rsp_q.pop_front();
                        xa = (e.k == 0);
                        xe = (e.k != 0);
                        if (m_ack[i] !== xa || m_err[i] !== xe || (xa && m_rdata !== e.rd)) begin
                            bad++; $display("FAIL rnd_resp: master %0d ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
                                            i, m_ack[i], m_err[i], m_rdata, xa, xe, e.rd);
                        end
                    end
                    opend[i] = 0; gnt[i] = 0; done++;
                    gap[i] = int'($urandom_range(0, 3));
                end
            end
            if (s_wen || s_ren) begin
                for (int i = 0; i < MN; i++) elig[i] = opend[i] && !gnt[i] && (rcyc[i] <= cyc - 2);
                g = rr_pick(elig, mdl_last);
                total++;
                if (g < 0) begin
                    bad++; $display("FAIL rnd_issue_unexpected: addr=%h with no eligible request", s_addr);
                end else begin
                    if ({s_addr, s_wdata, s_sel, s_wen, s_ren} !== {ra[g], rd[g], rs[g], rw[g], ~rw[g]}) begin
                        bad++; $display("FAIL rnd_issue: addr=%h wdata=%h sel=%h wen=%b ren=%b want master %0d addr=%h wdata=%h sel=%h wen=%b",
                                        s_addr, s_wdata, s_sel, s_wen, s_ren, g, ra[g], rd[g], rs[g], rw[g]);
                    end
                    gnt[g] = 1; mdl_last = g;
                end
            end
            m_wen = '0; m_ren = '0;
            for (int i = 0; i < MN; i++) begin
                if (!opend[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    else if (issued < N) begin
                        op    = int'($urandom_range(0, 2));
                        ra[i] = {4'(i + 4), 28'($urandom)};
                        rd[i] = $urandom;
                        rs[i] = 4'($urandom_range(1, 15));
                        rw[i] = (op != 0);
                        drive_req(i, op != 0, op != 1, ra[i], rd[i], rs[i]);
                        opend[i] = 1; rcyc[i] = cyc; issued++;
                    end
                end else if (!gnt[i] && cyc > rcyc[i] && $urandom_range(0, 7) == 0) begin
                    // Extra pulse of the opposite kind on a waiting master; must not change anything.
                    if (rw[i]) m_ren[i] = 1'b1;
                    else       m_wen[i] = 1'b1;
                end
            end
        end
        m_wen = '0; m_ren = '0;
        total++;
        if (done != N) begin bad++; $display("FAIL rnd_complete: %0d of %0d transfers answered", done, N); end
        slv_rand = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [MN-1:0] ack, err;
        int at, cnt;
        iss_q.delete(); rsp_q.delete();
        slv_kind = 2; slv_late = 0;
        drive_req(1, 1'b0, 1'b1, 32'h4030_0000, 32'h0, 4'hF);
        tick(); m_wen = '0; m_ren = '0;
        drive_req(0, 1'b1, 1'b0, 32'h4030_0004, 32'h1111_2222, 4'hF);
        tick(); m_wen = '0; m_ren = '0;
        tick(); tick();
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({m_ack, m_err, m_rdata, s_addr, s_wdata, s_sel, s_wen, s_ren} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: ack=%b err=%b rdata=%h addr=%h wdata=%h sel=%h wen=%b ren=%b want all 0",
                            m_ack, m_err, m_rdata, s_addr, s_wdata, s_sel, s_wen, s_ren);
        end
        cnt = 0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (m_ack != '0 || m_err != '0) cnt++;
        end
        rstn = 1'b1;
        mdl_last = MN - 1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (m_ack != '0 || m_err != '0) cnt++;
        end
        total++;
        if (cnt != 0) begin bad++; $display("FAIL mid_reset_resp: %0d response cycles, want 0", cnt); end
        total++;
        if (iss_q.size() != 1) begin bad++; $display("FAIL mid_reset_drop: %0d issues, want only the one before reset", iss_q.size()); end
        iss_q.delete(); rsp_q.delete();
        slv_kind = 0; slv_dly = 1;
        drive_req(1, 1'b0, 1'b1, 32'h4030_000C, 32'h0, 4'hF);
        drive_req(0, 1'b1, 1'b0, 32'h4030_0008, 32'h3333_4444, 4'hF);
        tick(); m_wen = '0; m_ren = '0;
        wait_resp(12, ack, err, at);
        total++;
        if (ack !== MN'(1 << rr_pick(2'b11, mdl_last))) begin
            bad++; $display("FAIL post_reset_first: ack=%b want master %0d", ack, rr_pick(2'b11, mdl_last));
        end
        wait_resp(12, ack, err, at);
        total++;
        if (iss_q.size() != 2 || iss_q[0].a !== 32'h4030_0008 || iss_q[1].a !== 32'h4030_000C) begin
            bad++; $display("FAIL post_reset_order: issues=%0d first=%h want 2 issues first=40300008",
                            iss_q.size(), (iss_q.size() > 0) ? iss_q[0].a : 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_routing();
        test_contention();
        test_timeout();
        test_slave_err();
        test_random();
        test_reset_mid();
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
